mmu_rx_bd_dispatch: RTL
=======================

// Module: mmu_rx_bd_dispatch
// PURPOSE
//  Downstream stage of the MMU TX BD path: consumes the 512-bit BD stream (bd2rx_s_axis_rq_*) produced by mmu_tx_bd.
//  Decodes each single-beat BD into a DDR write command or a DDR read command.
//  Tracks outstanding writes in an in-order SN queue and returns wr_ddr_rsp_en/wr_ddr_rsp_sn to the TX side on DDR write completion.
// PARAMETERS
//  MAX_WR_OS   16   max outstanding DDR writes (SN queue depth, power of 2, 2..64)
//  ERR_CNT_W   16   width of bd_err_cnt (saturating)
// PORTS
//  clk_sys                  in   1    system clock
//  rst                      in   1    synchronous reset, active-high
//  bd2rx_s_axis_rq_tdata    in   512  BD beat
//  bd2rx_s_axis_rq_tkeep    in   64   ignored
//  bd2rx_s_axis_rq_tuser    in   60   ignored
//  bd2rx_s_axis_rq_tlast    in   1    end of BD
//  bd2rx_s_axis_rq_tvalid   in   1    BD beat valid
//  bd2rx_s_axis_rq_tready   out  1    BD beat accepted
//  ddr_wcmd_valid/ready     out/in 1  DDR write command handshake
//  ddr_wcmd_addr/len/sn     out  64/32/11  dst addr, byte length, SN
//  ddr_rcmd_valid/ready     out/in 1  DDR read command handshake
//  ddr_rcmd_addr/len/sn     out  64/32/11  src addr, byte length, SN
//  ddr_wr_done              in   1    one pulse per completed write, in issue order
//  wr_ddr_rsp_en            out  1    write-response pulse to TX BD logic
//  wr_ddr_rsp_sn            out  11   SN of completed write
//  bd_err_cnt               out  ERR_CNT_W  bad-BD count, saturating
//  rx_bd_sta                out  4    {wr_q_full, wr_q_empty, fsm[1:0]}
// BEHAVIOUR
//  - BD fields: [7:0] opcode (8'h01 WR, 8'h02 RD), [18:8] sn, [63:32] len, [127:64] src_addr, [191:128] dst_addr.
//  - Reset: all *_valid, wr_ddr_rsp_en and tready = 0. Addr/len/sn outputs = 0. bd_err_cnt = 0. SN queue empty. FSM = IDLE.
//  - FSM IDLE(0): tready=1 unless wr_q_full. On tvalid&tready, register the beat:
//    * tlast=0 -> DROP(3), err+1.
//    * opcode WR -> ISSUE_WR(1).
//    * opcode RD -> ISSUE_RD(2).
//    * any other opcode -> stay IDLE, err+1.
//  - ISSUE_WR: wcmd_valid=1 with fields held stable. On wcmd_ready, push sn into the SN queue, then -> IDLE.
//  - ISSUE_RD: rcmd_valid=1, same handshake, no queue push, then -> IDLE.
//  - DROP: tready=1; discard beats up to and including tlast, then -> IDLE (one error per BD).
//  - tready=0 in ISSUE_WR/ISSUE_RD. Throughput: one BD per 2 cycles minimum.
//  - wr_q_full (MAX_WR_OS entries) gates acceptance in IDLE only. A BD already captured completes normally.
//  - Write BD with len=0: still issued and queued. Read BD with len=0: still issued.
//  - ddr_wr_done: pop the queue head. Next cycle: wr_ddr_rsp_en=1 for exactly 1 cycle, wr_ddr_rsp_sn=head sn.
//  - Same-cycle push and pop are both performed. Occupancy is unchanged, and full is not asserted by that push.
//  - ddr_wr_done while the queue is empty: ignored, err+1, no rsp pulse.
//  - bd_err_cnt saturates at all-ones.
//  - rst mid-command: valid drops next edge, queue cleared, and any outstanding responses are lost by design.
// CONFIGURATION
//  MMU_RX_BD_DFX_EN defined: adds outputs reg_rx_wr_bd_cnt[31:0] and reg_rx_rd_bd_cnt[31:0].
//    These count completed wcmd/rcmd handshakes, wrap at 2^32, and reset to 0.
//  MMU_RX_BD_DFX_EN undefined: these ports and their counters are absent. All other behaviour is identical.
// TESTING
//  T1 WR BD op=01 sn=0x123 len=0x40 dst=0x1000, ready=1 -> wcmd addr=0x1000 len=0x40 sn=0x123.
//     Then ddr_wr_done -> wr_ddr_rsp_en pulse, sn=0x123.
//  T2 RD BD op=02 sn=0x7FF src=0x2000 with rcmd_ready held 0 for 5 cycles.
//     -> rcmd_valid and fields stable, tready=0 throughout. Completes when ready rises.
//  T3 Push MAX_WR_OS=16 WR BDs without done -> tready=0 at the 17th BD.
//     One done -> 17th accepted. Responses come out in SN order.
//  T4 Opcode 8'h05, then a 3-beat BD (tlast on beat 3) -> bd_err_cnt=2, no commands issued.
//     Next valid BD is processed normally.
//  T5 ddr_wr_done on the same cycle as a wcmd handshake with the queue at 15 -> occupancy stays 15, tready stays 1.
//     Stray done while empty -> err+1, no rsp.
//  T6 Assert rst during ISSUE_WR -> wcmd_valid=0 and rx_bd_sta=4'b0100 after reset. With MMU_RX_BD_DFX_EN: counters=0.

Source files
------------

// File: rtl/mmu_rx_bd_dispatch.sv
// Decodes single-beat BDs into DDR write/read commands and returns in-order write responses (optional DFX counters: MMU_RX_BD_DFX_EN).
// Latency: BD capture -> cmd valid next cycle; ddr_wr_done -> wr_ddr_rsp_en next cycle; one BD per 2 cycles at best.
// Backpressure: tready low while a command waits for ready, or in IDLE while the write SN queue is full.
module mmu_rx_bd_dispatch #(
    parameter int MAX_WR_OS = 16,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic [511:0]         bd2rx_s_axis_rq_tdata,
    input  logic [63:0]          bd2rx_s_axis_rq_tkeep,
    input  logic [59:0]          bd2rx_s_axis_rq_tuser,
    input  logic                 bd2rx_s_axis_rq_tlast,
    input  logic                 bd2rx_s_axis_rq_tvalid,
    output logic                 bd2rx_s_axis_rq_tready,
    output logic                 ddr_wcmd_valid,
    input  logic                 ddr_wcmd_ready,
    output logic [63:0]          ddr_wcmd_addr,
    output logic [31:0]          ddr_wcmd_len,
    output logic [10:0]          ddr_wcmd_sn,
    output logic                 ddr_rcmd_valid,
    input  logic                 ddr_rcmd_ready,
    output logic [63:0]          ddr_rcmd_addr,
    output logic [31:0]          ddr_rcmd_len,
    output logic [10:0]          ddr_rcmd_sn,
    input  logic                 ddr_wr_done,
    output logic                 wr_ddr_rsp_en,
    output logic [10:0]          wr_ddr_rsp_sn,
    output logic [ERR_CNT_W-1:0] bd_err_cnt,
`ifdef MMU_RX_BD_DFX_EN
    output logic [31:0]          reg_rx_wr_bd_cnt,
    output logic [31:0]          reg_rx_rd_bd_cnt,
`endif
    output logic [3:0]           rx_bd_sta
);

    localparam logic [7:0] OP_WR = 8'h01;
    localparam logic [7:0] OP_RD = 8'h02;
    localparam int         AW    = $clog2(MAX_WR_OS);
    localparam int         CW    = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE_WR = 2'd1,
        ST_ISSUE_RD = 2'd2,
        ST_DROP     = 2'd3
    } state_e;

    state_e         state_q;
    logic           wcmd_valid_q, rcmd_valid_q;
    logic [63:0]    wcmd_addr_q, rcmd_addr_q;
    logic [31:0]    wcmd_len_q, rcmd_len_q;
    logic [10:0]    wcmd_sn_q, rcmd_sn_q;

    logic [10:0]    sn_mem_q [MAX_WR_OS];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  q_cnt_q, q_cnt_d;
    logic           rsp_en_q;
    logic [10:0]    rsp_sn_q;

    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [ERR_CNT_W:0]   err_sum;
    logic [1:0]           err_inc;

    logic [7:0]     bd_op;
    logic [10:0]    bd_sn;
    logic [31:0]    bd_len;
    logic [63:0]    bd_src, bd_dst;
    logic           q_full, q_empty, tready;
    logic           beat_acc, wcmd_fire, rcmd_fire;
    logic           q_push, q_pop, stray_done, cap_err;
    logic           unused_bits;

    assign bd_op  = bd2rx_s_axis_rq_tdata[7:0];
    assign bd_sn  = bd2rx_s_axis_rq_tdata[18:8];
    assign bd_len = bd2rx_s_axis_rq_tdata[63:32];
    assign bd_src = bd2rx_s_axis_rq_tdata[127:64];
    assign bd_dst = bd2rx_s_axis_rq_tdata[191:128];
    assign unused_bits = ^{bd2rx_s_axis_rq_tdata[511:192], bd2rx_s_axis_rq_tdata[31:19],
                           bd2rx_s_axis_rq_tkeep, bd2rx_s_axis_rq_tuser};

    assign q_full  = (q_cnt_q == FULL_CNT);
    assign q_empty = (q_cnt_q == '0);

    // Full only gates new captures; a BD already in ISSUE_WR still pushes its SN.
    assign tready    = !rst && (((state_q == ST_IDLE) && !q_full) || (state_q == ST_DROP));
    assign beat_acc  = bd2rx_s_axis_rq_tvalid && tready;
    assign wcmd_fire = wcmd_valid_q && ddr_wcmd_ready;
    assign rcmd_fire = rcmd_valid_q && ddr_rcmd_ready;

    assign q_push     = wcmd_fire;
    assign q_pop      = ddr_wr_done && !q_empty;
    assign stray_done = ddr_wr_done && q_empty;
    assign cap_err    = beat_acc && (state_q == ST_IDLE) &&
                        (!bd2rx_s_axis_rq_tlast || ((bd_op != OP_WR) && (bd_op != OP_RD)));

    // A bad BD and a stray done can land in the same cycle, so up to two errors per cycle.
    always_comb begin
        err_inc = {1'b0, cap_err} + {1'b0, stray_done};
        err_sum = {1'b0, err_q} + (ERR_CNT_W+1)'(err_inc);
        err_d   = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
        q_cnt_d = q_cnt_q + CW'(q_push) - CW'(q_pop);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wcmd_valid_q <= 1'b0;
            rcmd_valid_q <= 1'b0;
            wcmd_addr_q  <= '0;
            wcmd_len_q   <= '0;
            wcmd_sn_q    <= '0;
            rcmd_addr_q  <= '0;
            rcmd_len_q   <= '0;
            rcmd_sn_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (beat_acc) begin
                        if (!bd2rx_s_axis_rq_tlast) begin
                            state_q <= ST_DROP;
                        end else if (bd_op == OP_WR) begin
                            wcmd_valid_q <= 1'b1;
                            wcmd_addr_q  <= bd_dst;
                            wcmd_len_q   <= bd_len;
                            wcmd_sn_q    <= bd_sn;
                            state_q      <= ST_ISSUE_WR;
                        end else if (bd_op == OP_RD) begin
                            rcmd_valid_q <= 1'b1;
                            rcmd_addr_q  <= bd_src;
                            rcmd_len_q   <= bd_len;
                            rcmd_sn_q    <= bd_sn;
                            state_q      <= ST_ISSUE_RD;
                        end
                    end
                end
                ST_ISSUE_WR: begin
                    if (ddr_wcmd_ready) begin
                        wcmd_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_ISSUE_RD: begin
                    if (ddr_rcmd_ready) begin
                        rcmd_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (beat_acc && bd2rx_s_axis_rq_tlast) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (q_push) begin
            sn_mem_q[wr_ptr_q] <= wcmd_sn_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            q_cnt_q  <= '0;
            rsp_en_q <= 1'b0;
            rsp_sn_q <= '0;
            err_q    <= '0;
        end else begin
            q_cnt_q  <= q_cnt_d;
            rsp_en_q <= q_pop;
            err_q    <= err_d;
            if (q_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (q_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                rsp_sn_q <= sn_mem_q[rd_ptr_q];
            end
        end
    end

`ifdef MMU_RX_BD_DFX_EN
    logic [31:0] wr_bd_cnt_q, rd_bd_cnt_q;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wr_bd_cnt_q <= '0;
            rd_bd_cnt_q <= '0;
        end else begin
            if (wcmd_fire) begin
                wr_bd_cnt_q <= wr_bd_cnt_q + 32'd1;
            end
            if (rcmd_fire) begin
                rd_bd_cnt_q <= rd_bd_cnt_q + 32'd1;
            end
        end
    end

    assign reg_rx_wr_bd_cnt = wr_bd_cnt_q;
    assign reg_rx_rd_bd_cnt = rd_bd_cnt_q;
`endif

    assign bd2rx_s_axis_rq_tready = tready;
    assign ddr_wcmd_valid = wcmd_valid_q;
    assign ddr_wcmd_addr  = wcmd_addr_q;
    assign ddr_wcmd_len   = wcmd_len_q;
    assign ddr_wcmd_sn    = wcmd_sn_q;
    assign ddr_rcmd_valid = rcmd_valid_q;
    assign ddr_rcmd_addr  = rcmd_addr_q;
    assign ddr_rcmd_len   = rcmd_len_q;
    assign ddr_rcmd_sn    = rcmd_sn_q;
    assign wr_ddr_rsp_en  = rsp_en_q;
    assign wr_ddr_rsp_sn  = rsp_sn_q;
    assign bd_err_cnt     = err_q;
    assign rx_bd_sta      = {q_full, q_empty, state_q};

endmodule
